// File: rtl/page_mapper.sv
// page_mapper: windowed virtual-to-physical page translation for a 16-bit CPU.
// Combinational lookup over NWIN windows, a byte-wide register file, and
// fault capture with a level interrupt.
// Optional feature: define PAGE_MAPPER_WP_EN for per-window write protect.
module page_mapper #(
  parameter int NWIN      = 4,
  parameter int PAGE_BITS = 5,
  parameter int PHYS_BITS = 6
) (
  input  logic                            i_clk,
  input  logic                            i_rst,
  input  logic [15:0]                     i_address,
  input  logic                            i_req,
  input  logic                            i_rw,
  input  logic                            i_bypass,
  input  logic                            i_cs,
  input  logic [2:0]                      i_ad,
  input  logic [7:0]                      i_din,
  output logic [7:0]                      o_dout,
  output logic                            o_hit,
  output logic [2:0]                      o_win,
  output logic [PHYS_BITS+15-PAGE_BITS:0] o_phys_addr,
  output logic                            o_mem_we,
  output logic                            o_intr
);
  localparam int OFF_BITS = 16 - PAGE_BITS;
  localparam int SELW     = $clog2(NWIN);

  logic [NWIN-1:0][PAGE_BITS-1:0] w_vtag;
  logic [NWIN-1:0][PHYS_BITS-1:0] w_phys;
  logic [NWIN-1:0]                w_valid;
  logic [NWIN-1:0]                w_wp;
  logic [SELW-1:0]                r_sel;
  logic [2:0]                     r_status;
  logic [PAGE_BITS-1:0]           r_fpage;
  logic                           r_intr;
  logic [PAGE_BITS-1:0]           w_page;
  logic                           w_hit;
  logic [SELW-1:0]                w_idx;
  logic                           w_wr, w_clr, w_miss, w_wpf, w_fault, w_wp_hit;

  assign w_page = i_address[15:OFF_BITS];
  assign w_wr   = i_cs & ~i_rw;
  assign w_clr  = w_wr & (i_ad == 3'd4) & i_din[0];

  // Per-window state; each window only listens when it is the selected one.
  for (genvar g = 0; g < NWIN; g++) begin : g_win
    logic [PAGE_BITS-1:0] r_vtag;
    logic [PHYS_BITS-1:0] r_phys;
    logic                 r_valid;
    logic                 w_selw;
    assign w_selw = w_wr & (r_sel == SELW'(g));

    // VTAG / PHYS / VALID programming through the register file
    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
        r_vtag  <= PAGE_BITS'(g + 1);
        r_phys  <= PHYS_BITS'(g);
        r_valid <= (g < 2);
      end else if (w_selw) begin
        if (i_ad == 3'd1) r_vtag  <= i_din[7:8-PAGE_BITS];
        if (i_ad == 3'd2) r_phys  <= i_din[PHYS_BITS-1:0];
        if (i_ad == 3'd3) r_valid <= i_din[0];
      end
    end

`ifdef PAGE_MAPPER_WP_EN
    logic r_wp;
    // Write-protect bit lives alongside VALID in CTRL
    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst)                          r_wp <= 1'b0;
      else if (w_selw && i_ad == 3'd3)    r_wp <= i_din[1];
    end
    assign w_wp[g] = r_wp;
`else
    assign w_wp[g] = 1'b0;
`endif

    assign w_vtag[g]  = r_vtag;
    assign w_phys[g]  = r_phys;
    assign w_valid[g] = r_valid;
  end

  // Priority match: scan high to low so the lowest matching index wins
  always_comb begin
    w_hit = 1'b0;
    w_idx = '0;
    for (int i = NWIN - 1; i >= 0; i--) begin
      if (w_valid[i] && (w_vtag[i] == w_page)) begin
        w_hit = 1'b1;
        w_idx = SELW'(i);
      end
    end
  end

  assign w_wp_hit    = w_hit & w_wp[w_idx];
  assign o_hit       = w_hit;
  assign o_win       = 3'(w_idx);
  assign o_phys_addr = {w_phys[w_idx], i_address[OFF_BITS-1:0]};
  assign o_mem_we    = ~i_rw & i_req & w_hit & ~w_wp_hit;
  assign o_intr      = r_intr;

  assign w_miss  = i_req & ~i_bypass & ~i_cs & ~w_hit;
  assign w_wpf   = i_req & ~i_rw & w_wp_hit;
  assign w_fault = w_miss | w_wpf;

  // Window select; out-of-range indices are dropped
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)                                      r_sel <= '0;
    else if (w_wr && i_ad == 3'd0 && int'(i_din) < NWIN) r_sel <= i_din[SELW-1:0];
  end

  // Fault capture: a same-cycle clear is overridden by a new fault, which is
  // then recorded as a fresh first fault rather than an overrun
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_status <= '0;
      r_fpage  <= '0;
      r_intr   <= 1'b0;
    end else if (w_fault) begin
      r_intr <= 1'b1;
      if (r_status[0] && !w_clr) begin
        r_status[2] <= 1'b1;
      end else begin
        r_status <= {1'b0, w_wpf, 1'b1};
        r_fpage  <= w_page;
      end
    end else if (w_clr) begin
      r_status <= '0;
      r_intr   <= 1'b0;
    end
  end

  // Combinational register read mux; unused bits read zero
  always_comb begin
    o_dout = '0;
    case (i_ad)
      3'd0: o_dout = 8'(r_sel);
      3'd1: o_dout[7:8-PAGE_BITS] = w_vtag[r_sel];
      3'd2: o_dout[PHYS_BITS-1:0] = w_phys[r_sel];
      3'd3: o_dout[1:0] = {w_wp[r_sel], w_valid[r_sel]};
      3'd4: o_dout[2:0] = r_status;
      3'd5: o_dout[7:8-PAGE_BITS] = r_fpage;
      3'd6: o_dout = {3'(NWIN - 1), 3'(PAGE_BITS), 2'b00};
      default: o_dout = '0;
    endcase
  end
endmodule

// File: tb/tb_page_mapper.sv
// Directed table-driven bench for page_mapper (NWIN=4, PAGE_BITS=5, PHYS_BITS=6).
module tb_page_mapper;
`ifdef PAGE_MAPPER_WP_EN
  localparam bit WP = 1'b1;
`else
  localparam bit WP = 1'b0;
`endif

  logic        clk, rst;
  logic [15:0] address;
  logic        req, rw, bypass, cs;
  logic [2:0]  ad;
  logic [7:0]  din, dout;
  logic        hit, mem_we, intr;
  logic [2:0]  win;
  logic [16:0] phys_addr;

  page_mapper #(.NWIN(4), .PAGE_BITS(5), .PHYS_BITS(6)) dut (
    .i_clk(clk), .i_rst(rst), .i_address(address), .i_req(req), .i_rw(rw),
    .i_bypass(bypass), .i_cs(cs), .i_ad(ad), .i_din(din), .o_dout(dout),
    .o_hit(hit), .o_win(win), .o_phys_addr(phys_addr), .o_mem_we(mem_we),
    .o_intr(intr));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        req, rw, byp, cs;
    logic [2:0]  ad;
    logic [7:0]  din;
    logic [15:0] addr;
    bit          cx;
    logic        hit;
    logic [2:0]  win;
    logic [16:0] pa;
    logic        we;
    bit          cr;
    logic [7:0]  dout;
    logic        intr;
  } vec_t;

  vec_t v[80];
  int   nv = 0;
  int   npass = 0, ntotal = 0;

  task automatic mk(string n, logic rq, logic r, logic b, logic c, logic [2:0] a,
                    logic [7:0] d, logic [15:0] ad_, bit cx, logic h, logic [2:0] w,
                    logic [16:0] p, logic we, bit cr, logic [7:0] dv, logic it);
    v[nv] = '{n, rq, r, b, c, a, d, ad_, cx, h, w, p, we, cr, dv, it};
    nv++;
  endtask
  task automatic rd(string n, logic [2:0] a, logic [7:0] dv, logic it);
    mk(n, 0, 1, 0, 1, a, 8'h00, 16'h0000, 0, 0, 0, 0, 0, 1, dv, it);
  endtask
  task automatic wr(string n, logic [2:0] a, logic [7:0] d, logic it);
    mk(n, 0, 0, 0, 1, a, d, 16'h0000, 0, 0, 0, 0, 0, 0, 8'h00, it);
  endtask
  task automatic xl(string n, logic rq, logic r, logic b, logic [15:0] a, logic h,
                    logic [2:0] w, logic [16:0] p, logic we, logic it);
    mk(n, rq, r, b, 0, 3'd0, 8'h00, a, 1, h, w, p, we, 0, 8'h00, it);
  endtask

  task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
    ntotal++;
    if (act !== exp) $display("FAIL %s actual=%h required=%h", n, act, exp);
    else npass++;
  endtask

  task automatic idle();
    req = 0; rw = 1; bypass = 0; cs = 0; ad = 0; din = 0; address = 0;
  endtask

  initial begin
    idle();
    rst = 1'b1;
    // ---- vector table ----
    rd("id", 6, 8'h74, 0);
    rd("status0", 4, 8'h00, 0);
    rd("fpage0", 5, 8'h00, 0);
    rd("sel0", 0, 8'h00, 0);
    rd("vtag0", 1, 8'h08, 0);
    rd("phys0", 2, 8'h00, 0);
    rd("ctrl0", 3, 8'h01, 0);
    rd("reg7", 7, 8'h00, 0);
    xl("rd0800", 1, 1, 0, 16'h0800, 1, 0, 17'h00000, 0, 0);
    xl("rd1234", 1, 1, 0, 16'h1234, 1, 1, 17'h00A34, 0, 0);
    xl("wr1234", 1, 0, 0, 16'h1234, 1, 1, 17'h00A34, 1, 0);
    xl("miss4000", 1, 1, 0, 16'h4000, 0, 0, 17'h00000, 0, 0);
    rd("st_miss", 4, 8'h01, 1);
    rd("fp_miss", 5, 8'h40, 1);
    wr("clr", 4, 8'h01, 1);
    rd("st_clr", 4, 8'h00, 0);
    xl("byp4000", 1, 1, 1, 16'h4000, 0, 0, 17'h00000, 0, 0);
    rd("st_byp", 4, 8'h00, 0);
    xl("miss_a", 1, 1, 0, 16'h4000, 0, 0, 17'h00000, 0, 0);
    xl("miss_b", 1, 1, 0, 16'h6000, 0, 0, 17'h00000, 0, 1);
    rd("st_ovr", 4, 8'h05, 1);
    rd("fp_ovr", 5, 8'h40, 1);
    wr("clr2", 4, 8'h01, 1);
    rd("st_clr2", 4, 8'h00, 0);
    wr("sel2", 0, 8'h02, 0);
    wr("vtag2", 1, 8'h40, 0);
    wr("phys2", 2, 8'h15, 0);
    wr("ctrl2", 3, 8'h01, 0);
    wr("sel_oor", 0, 8'h05, 0);
    rd("sel_rd", 0, 8'h02, 0);
    rd("vtag_rd", 1, 8'h40, 0);
    rd("phys_rd", 2, 8'h15, 0);
    rd("ctrl_rd", 3, 8'h01, 0);
    xl("rd4123", 1, 1, 0, 16'h4123, 1, 2, 17'h0A923, 0, 0);
    // window invalidated in the same cycle still translates with old contents
    mk("same_cyc", 1, 0, 0, 1, 3'd3, 8'h00, 16'h4123, 1, 1, 2, 17'h0A923, 1, 0, 8'h00, 0);
    xl("after_inv", 0, 1, 0, 16'h4123, 0, 0, 17'h00123, 0, 0);
    wr("ctrl_wp", 3, 8'h03, 0);
    rd("ctrl_wp_rd", 3, WP ? 8'h03 : 8'h01, 0);
    xl("wp_wr", 1, 0, 0, 16'h4000, 1, 2, 17'h0A800, !WP, 0);
    rd("st_wp", 4, WP ? 8'h03 : 8'h00, WP);
    rd("fp_wp", 5, 8'h40, WP);
    xl("wp_rd", 1, 1, 0, 16'h4000, 1, 2, 17'h0A800, 0, WP);
    xl("wp_wr2", 1, 0, 0, 16'h4000, 1, 2, 17'h0A800, !WP, WP);
    rd("st_wp_ovr", 4, WP ? 8'h07 : 8'h00, WP);
    // clear and write-protect fault in the same cycle: fault wins
    mk("clr_wp", 1, 0, 0, 1, 3'd4, 8'h01, 16'h4000, 0, 0, 0, 0, 0, 0, 8'h00, WP);
    rd("st_clr_wp", 4, WP ? 8'h03 : 8'h00, WP);
    wr("clr3", 4, 8'h01, WP);
    rd("st_clr3", 4, 8'h00, 0);
    wr("sel3", 0, 8'h03, 0);
    wr("vtag3", 1, 8'h10, 0);
    wr("ctrl3", 3, 8'h01, 0);
    wr("sel0b", 0, 8'h00, 0);
    wr("vtag0b", 1, 8'h10, 0);
    xl("multi", 0, 1, 0, 16'h1000, 1, 0, 17'h00000, 0, 0);
    wr("ctrl0off", 3, 8'h00, 0);
    xl("multi2", 0, 1, 0, 16'h1000, 1, 1, 17'h00800, 0, 0);

    // ---- reset ----
    repeat (2) @(posedge clk);
    #1 chk("rst_intr", 32'(intr), 32'd0);
    @(negedge clk) rst = 1'b0;

    // ---- apply table ----
    for (int i = 0; i < nv; i++) begin
      @(negedge clk);
      req = v[i].req; rw = v[i].rw; bypass = v[i].byp; cs = v[i].cs;
      ad = v[i].ad; din = v[i].din; address = v[i].addr;
      #1;
      chk({v[i].name, ".intr"}, 32'(intr), 32'(v[i].intr));
      if (v[i].cx) begin
        chk({v[i].name, ".hit"}, 32'(hit), 32'(v[i].hit));
        chk({v[i].name, ".win"}, 32'(win), 32'(v[i].win));
        chk({v[i].name, ".pa"}, 32'(phys_addr), 32'(v[i].pa));
        chk({v[i].name, ".we"}, 32'(mem_we), 32'(v[i].we));
      end
      if (v[i].cr) chk({v[i].name, ".dout"}, 32'(dout), 32'(v[i].dout));
    end

    // ---- async reset while interrupt pending ----
    @(negedge clk) idle(); req = 1; address = 16'h6000;
    @(negedge clk) #1 chk("pre_rst_intr", 32'(intr), 32'd1);
    #1 rst = 1'b1;
    #1 chk("rst_async_intr", 32'(intr), 32'd0);
    repeat (2) @(posedge clk);          // miss held during reset must not record
    @(negedge clk) idle(); rst = 1'b0;
    #1 chk("post_rst_intr", 32'(intr), 32'd0);
    cs = 1; ad = 3'd4;
    #1 chk("post_rst_status", 32'(dout), 32'h00);
    ad = 3'd1;
    #1 chk("post_rst_vtag0", 32'(dout), 32'h08);
    ad = 3'd5;
    #1 chk("post_rst_fpage", 32'(dout), 32'h00);
    cs = 0; address = 16'h1234;
    #1 chk("post_rst_win", 32'(win), 32'd1);

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end
endmodule
